// File: rtl/galois_lfsr_checker.sv
// galois_lfsr_checker
//   Checks a received pseudo-random bit stream against the polynomial
//   x^8+x^4+x^3+x^2+1. The checker hunts for the sequence by self-seeding
//   from the input. It declares lock after LOCK_BITS consecutive correctly
//   predicted bits. Once locked, it free-runs its own reference so that
//   every corrupted input bit counts as exactly one error. Lock is dropped
//   when UNLOCK_ERRS errors land inside one 64-bit window.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        synchronous active-high reset
//   data_valid   data_in holds a word this cycle
//   data_in      BITS_PER_CLOCK received bits, [BITS_PER_CLOCK-1] oldest, [0] newest
//   clear_count  single-cycle clear of error_count
//   locked       checker is synchronised to the sequence
//   err_valid    err_bits valid (data_valid delayed one cycle)
//   err_bits     per-bit mismatch flags of the previously accepted word
//   error_count  saturating count of bit errors seen while locked
//   bit_count    count of bits checked while locked (wraps at 2^32)
//
// Build option
//   LFSR_CHECKER_BITCOUNT_EN  when defined, bit_count is a live counter;
//                             otherwise bit_count is tied to zero.
module galois_lfsr_checker #(
  parameter int BITS_PER_CLOCK = 1,
  parameter int LOCK_BITS      = 32,
  parameter int UNLOCK_ERRS    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      data_valid,
  input  logic [BITS_PER_CLOCK-1:0] data_in,
  input  logic                      clear_count,
  output logic                      locked,
  output logic                      err_valid,
  output logic [BITS_PER_CLOCK-1:0] err_bits,
  output logic [15:0]               error_count,
  output logic [31:0]               bit_count
);

  localparam logic [15:0] LOCK_RUN = 16'(LOCK_BITS);
  localparam logic [7:0]  UNLOCK_W = 8'(UNLOCK_ERRS);
  localparam logic [6:0]  WIN_LAST = 7'(64 / BITS_PER_CLOCK - 1);

  typedef enum logic {ST_HUNT, ST_LOCKED} state_t;

  state_t                    state_q, state_d;
  logic [7:0]                hist_q, hist_d;
  logic [3:0]                fill_q, fill_d;
  logic [15:0]               run_q, run_d;
  logic [6:0]                win_cnt_q;
  logic [7:0]                win_err_q, win_err_sum;
  logic [BITS_PER_CLOCK-1:0] errs;
  logic [2:0]                word_errs;
  logic                      pred;
  logic [15:0]               ec_base, ec_d;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {14'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Word evaluation: bits are walked oldest first so each one sees the
  // history left by its predecessor in the same word.
  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    run_d     = run_q;
    errs      = '0;
    word_errs = 3'd0;
    pred      = 1'b0;
    for (int i = BITS_PER_CLOCK - 1; i >= 0; i--) begin
      // hist[k] holds s[n-1-k]; taps are s[n-4], s[n-5], s[n-6], s[n-8]
      pred = hist_d[3] ^ hist_d[4] ^ hist_d[5] ^ hist_d[7];
      if (state_q == ST_LOCKED) begin
        errs[i]   = data_in[i] ^ pred;
        word_errs = word_errs + {2'b0, errs[i]};
        // Reference free-runs so one bad bit cannot poison later predictions
        hist_d    = {hist_d[6:0], pred};
      end else begin
        if (fill_d != 4'd8) begin
          fill_d = fill_d + 4'd1;
        end else if ((data_in[i] == pred) && (hist_d != 8'd0)) begin
          if (run_d != 16'hFFFF) begin
            run_d = run_d + 16'd1;
          end
        end else begin
          run_d = 16'd0;
        end
        hist_d = {hist_d[6:0], data_in[i]};
      end
    end

    win_err_sum = win_err_q + {5'b0, word_errs};

    state_d = state_q;
    if (data_valid) begin
      if (state_q == ST_HUNT) begin
        if (run_d >= LOCK_RUN) begin
          state_d = ST_LOCKED;
        end
      end else if (win_err_sum >= UNLOCK_W) begin
        state_d = ST_HUNT;
      end
    end

    // A clear in the same cycle as an erroring word keeps only that word's errors
    ec_base = clear_count ? 16'd0 : error_count;
    ec_d    = ec_base;
    if (data_valid && (state_q == ST_LOCKED)) begin
      ec_d = sat_add16(ec_base, word_errs);
    end
  end

  // Registered state and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HUNT;
      hist_q      <= 8'd0;
      fill_q      <= 4'd0;
      run_q       <= 16'd0;
      win_cnt_q   <= 7'd0;
      win_err_q   <= 8'd0;
      locked      <= 1'b0;
      err_valid   <= 1'b0;
      err_bits    <= '0;
      error_count <= 16'd0;
    end else begin
      state_q     <= state_d;
      locked      <= (state_d == ST_LOCKED);
      err_valid   <= data_valid;
      err_bits    <= data_valid ? errs : '0;
      error_count <= ec_d;
      if (data_valid) begin
        if ((state_q == ST_LOCKED) && (state_d == ST_HUNT)) begin
          hist_q    <= 8'd0;
          fill_q    <= 4'd0;
          run_q     <= 16'd0;
          win_cnt_q <= 7'd0;
          win_err_q <= 8'd0;
        end else if (state_q == ST_LOCKED) begin
          hist_q <= hist_d;
          if (win_cnt_q == WIN_LAST) begin
            win_cnt_q <= 7'd0;
            win_err_q <= 8'd0;
          end else begin
            win_cnt_q <= win_cnt_q + 7'd1;
            win_err_q <= win_err_sum;
          end
        end else begin
          hist_q <= hist_d;
          fill_q <= fill_d;
          run_q  <= run_d;
        end
      end
    end
  end

`ifdef LFSR_CHECKER_BITCOUNT_EN
  localparam logic [31:0] BPC_W = 32'(BITS_PER_CLOCK);

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_count <= 32'd0;
    end else if (data_valid && (state_q == ST_LOCKED)) begin
      bit_count <= bit_count + BPC_W;
    end
  end
`else
  assign bit_count = 32'd0;
`endif

endmodule

// File: tb/tb_galois_lfsr_checker.sv
module tb_galois_lfsr_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        dv1, clr1, lk1, ev1;
  logic [0:0]  din1, eb1;
  logic [15:0] ec1;
  logic [31:0] bc1;
  logic        dv4, clr4, lk4, ev4;
  logic [3:0]  din4, eb4;
  logic [15:0] ec4;
  logic [31:0] bc4;

  int total = 0;
  int bad = 0;
  logic [7:0]  g1, g4;
  int          lw1, lw4;
  logic [31:0] exp_bc;

`ifdef LFSR_CHECKER_BITCOUNT_EN
  localparam bit BC_EN = 1'b1;
`else
  localparam bit BC_EN = 1'b0;
`endif

  galois_lfsr_checker #(.BITS_PER_CLOCK(1), .LOCK_BITS(32), .UNLOCK_ERRS(8)) dut1 (
    .clk(clk), .reset(reset), .data_valid(dv1), .data_in(din1), .clear_count(clr1),
    .locked(lk1), .err_valid(ev1), .err_bits(eb1), .error_count(ec1), .bit_count(bc1)
  );

  galois_lfsr_checker #(.BITS_PER_CLOCK(4), .LOCK_BITS(32), .UNLOCK_ERRS(100)) dut4 (
    .clk(clk), .reset(reset), .data_valid(dv4), .data_in(din4), .clear_count(clr4),
    .locked(lk4), .err_valid(ev4), .err_bits(eb4), .error_count(ec4), .bit_count(bc4)
  );

  function automatic logic [7:0] gstep(input logic [7:0] g);
    return g[0] ? ((g >> 1) ^ 8'hB8) : (g >> 1);
  endfunction

  task automatic gbit1(output logic b);
    b  = g1[0];
    g1 = gstep(g1);
  endtask

  task automatic gword4(output logic [3:0] w);
    for (int k = 3; k >= 0; k--) begin
      w[k] = g4[0];
      g4   = gstep(g4);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word1(input logic v, input logic d, input logic c);
    dv1 = v; din1[0] = d; clr1 = c;
    tick();
  endtask

  task automatic word4(input logic v, input logic [3:0] d);
    dv4 = v; din4 = d;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dv1 = 1'b1; din1 = 1'b1; clr1 = 1'b0;
    dv4 = 1'b1; din4 = 4'hF; clr4 = 1'b0;
    tick(); tick();
    total++; if (lk1 !== 1'b0) begin bad++; $display("FAIL reset_locked1 got=%b exp=0", lk1); end
    total++; if (ev1 !== 1'b0) begin bad++; $display("FAIL reset_err_valid1 got=%b exp=0", ev1); end
    total++; if (eb1 !== 1'b0) begin bad++; $display("FAIL reset_err_bits1 got=%b exp=0", eb1); end
    total++; if (ec1 !== 16'd0) begin bad++; $display("FAIL reset_error_count1 got=%0d exp=0", ec1); end
    total++; if (bc1 !== 32'd0) begin bad++; $display("FAIL reset_bit_count1 got=%0d exp=0", bc1); end
    total++; if (lk4 !== 1'b0) begin bad++; $display("FAIL reset_locked4 got=%b exp=0", lk4); end
    total++; if (ev4 !== 1'b0) begin bad++; $display("FAIL reset_err_valid4 got=%b exp=0", ev4); end
    total++; if (eb4 !== 4'h0) begin bad++; $display("FAIL reset_err_bits4 got=%h exp=0", eb4); end
    total++; if (ec4 !== 16'd0) begin bad++; $display("FAIL reset_error_count4 got=%0d exp=0", ec4); end
    total++; if (bc4 !== 32'd0) begin bad++; $display("FAIL reset_bit_count4 got=%0d exp=0", bc4); end
    reset = 1'b0; dv1 = 1'b0; dv4 = 1'b0;
  endtask

  task automatic test_lock();
    logic b;
    g1 = 8'h01; lw1 = 0;
    for (int n = 1; n <= 39; n++) begin
      gbit1(b); word1(1'b1, b, 1'b0);
    end
    total++; if (lk1 !== 1'b0) begin bad++; $display("FAIL lock_early got=%b exp=0", lk1); end
    gbit1(b); word1(1'b1, b, 1'b0);
    total++; if (lk1 !== 1'b1) begin bad++; $display("FAIL lock_40th got=%b exp=1", lk1); end
    total++; if (ev1 !== 1'b1) begin bad++; $display("FAIL lock_err_valid got=%b exp=1", ev1); end
    total++; if (ec1 !== 16'd0) begin bad++; $display("FAIL lock_error_count got=%0d exp=0", ec1); end
  endtask

  task automatic test_single_err();
    logic b;
    int   seen;
    for (int n = 0; n < 10; n++) begin
      gbit1(b); word1(1'b1, b, 1'b0); lw1++;
    end
    gbit1(b); word1(1'b1, ~b, 1'b0); lw1++;
    total++; if (eb1 !== 1'b1) begin bad++; $display("FAIL single_err_bits got=%b exp=1", eb1); end
    total++; if (ec1 !== 16'd1) begin bad++; $display("FAIL single_err_count got=%0d exp=1", ec1); end
    total++; if (lk1 !== 1'b1) begin bad++; $display("FAIL single_err_locked got=%b exp=1", lk1); end
    word1(1'b0, 1'b1, 1'b0);
    total++; if (ev1 !== 1'b0) begin bad++; $display("FAIL idle_err_valid got=%b exp=0", ev1); end
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      gbit1(b); word1(1'b1, b, 1'b0); lw1++;
      if (eb1 !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL single_err_followups got=%0d exp=0", seen); end
    total++; if (ec1 !== 16'd1) begin bad++; $display("FAIL single_err_count_hold got=%0d exp=1", ec1); end
  endtask

  task automatic test_clear();
    logic b;
    for (int n = 0; n < 4; n++) begin
      gbit1(b); word1(1'b1, ~b, 1'b0); lw1++;
    end
    total++; if (ec1 !== 16'd5) begin bad++; $display("FAIL clear_pre_count got=%0d exp=5", ec1); end
    gbit1(b); word1(1'b1, ~b, 1'b1); lw1++;
    total++; if (ec1 !== 16'd1) begin bad++; $display("FAIL clear_with_err got=%0d exp=1", ec1); end
    total++; if (lk1 !== 1'b1) begin bad++; $display("FAIL clear_locked got=%b exp=1", lk1); end
    gbit1(b); word1(1'b1, b, 1'b1); lw1++;
    total++; if (ec1 !== 16'd0) begin bad++; $display("FAIL clear_plain got=%0d exp=0", ec1); end
  endtask

  task automatic test_unlock();
    logic b;
    while (lw1 % 64 != 0) begin
      gbit1(b); word1(1'b1, b, 1'b0); lw1++;
    end
    for (int k = 0; k < 32; k++) begin
      gbit1(b);
      word1(1'b1, (k % 4 == 3) ? ~b : b, 1'b0);
      lw1++;
      if (k == 27) begin
        total++; if (lk1 !== 1'b1) begin bad++; $display("FAIL unlock_7th_locked got=%b exp=1", lk1); end
      end
      if (k == 31) begin
        exp_bc = BC_EN ? 32'(lw1) : 32'd0;
        total++; if (lk1 !== 1'b0) begin bad++; $display("FAIL unlock_8th_locked got=%b exp=0", lk1); end
        total++; if (ec1 !== 16'd8) begin bad++; $display("FAIL unlock_count got=%0d exp=8", ec1); end
        total++; if (eb1 !== 1'b1) begin bad++; $display("FAIL unlock_err_bits got=%b exp=1", eb1); end
        total++; if (bc1 !== exp_bc) begin bad++; $display("FAIL unlock_bit_count got=%0d exp=%0d", bc1, exp_bc); end
      end
    end
    gbit1(b); word1(1'b1, ~b, 1'b0);
    total++; if (eb1 !== 1'b0) begin bad++; $display("FAIL hunt_err_bits got=%b exp=0", eb1); end
    total++; if (ec1 !== 16'd8) begin bad++; $display("FAIL hunt_count_hold got=%0d exp=8", ec1); end
    total++; if (bc1 !== exp_bc) begin bad++; $display("FAIL hunt_bit_count_hold got=%0d exp=%0d", bc1, exp_bc); end
  endtask

  task automatic test_zeros();
    int nlock;
    reset = 1'b1; dv1 = 1'b0; dv4 = 1'b0;
    tick();
    reset = 1'b0;
    nlock = 0;
    for (int n = 0; n < 200; n++) begin
      word1(1'b1, 1'b0, 1'b0);
      if (lk1 !== 1'b0) nlock++;
    end
    total++; if (nlock != 0) begin bad++; $display("FAIL zeros_locked cycles=%0d exp=0", nlock); end
    total++; if (ec1 !== 16'd0) begin bad++; $display("FAIL zeros_count got=%0d exp=0", ec1); end
    dv1 = 1'b0;
  endtask

  task automatic test_wide_gaps();
    logic [3:0] w;
    int gap, gap_bad;
    g4 = 8'h01; lw4 = 0; gap_bad = 0;
    for (int n = 1; n <= 15; n++) begin
      gap = int'($urandom_range(0, 2));
      for (int j = 0; j < gap; j++) begin
        word4(1'b0, 4'($urandom_range(0, 15)));
        if (ev4 !== 1'b0) gap_bad++;
      end
      gword4(w); word4(1'b1, w);
      if (n > 10) lw4++;
      if (n == 9) begin
        total++; if (lk4 !== 1'b0) begin bad++; $display("FAIL wide_lock_9th got=%b exp=0", lk4); end
      end
      if (n == 10) begin
        total++; if (lk4 !== 1'b1) begin bad++; $display("FAIL wide_lock_10th got=%b exp=1", lk4); end
      end
    end
    exp_bc = BC_EN ? 32'(lw4 * 4) : 32'd0;
    total++; if (gap_bad != 0) begin bad++; $display("FAIL wide_gap_err_valid got=%0d exp=0", gap_bad); end
    total++; if (bc4 !== exp_bc) begin bad++; $display("FAIL wide_bit_count got=%0d exp=%0d", bc4, exp_bc); end
    total++; if (ec4 !== 16'd0) begin bad++; $display("FAIL wide_error_count got=%0d exp=0", ec4); end
    total++; if (lk4 !== 1'b1) begin bad++; $display("FAIL wide_locked got=%b exp=1", lk4); end
  endtask

  task automatic test_saturate();
    logic [3:0] w;
    for (int n = 0; n < 16383; n++) begin
      gword4(w); word4(1'b1, w ^ 4'hF); lw4++;
    end
    total++; if (ec4 !== 16'd65532) begin bad++; $display("FAIL sat_pre got=%0d exp=65532", ec4); end
    total++; if (lk4 !== 1'b1) begin bad++; $display("FAIL sat_locked got=%b exp=1", lk4); end
    gword4(w); word4(1'b1, w ^ 4'hE); lw4++;
    total++; if (ec4 !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got=%h exp=ffff", ec4); end
    total++; if (eb4 !== 4'hE) begin bad++; $display("FAIL sat_err_bits got=%h exp=e", eb4); end
    gword4(w); word4(1'b1, w ^ 4'h1); lw4++;
    total++; if (ec4 !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", ec4); end
    total++; if (eb4 !== 4'h1) begin bad++; $display("FAIL sat_err_bits2 got=%h exp=1", eb4); end
    exp_bc = BC_EN ? 32'(lw4 * 4) : 32'd0;
    total++; if (bc4 !== exp_bc) begin bad++; $display("FAIL sat_bit_count got=%0d exp=%0d", bc4, exp_bc); end
  endtask

  task automatic test_reset_locked();
    logic [3:0] w;
    reset = 1'b1; clr4 = 1'b1;
    gword4(w); word4(1'b1, w ^ 4'hF);
    reset = 1'b0; clr4 = 1'b0; dv4 = 1'b0;
    total++; if (lk4 !== 1'b0) begin bad++; $display("FAIL rst_lock_locked got=%b exp=0", lk4); end
    total++; if (ev4 !== 1'b0) begin bad++; $display("FAIL rst_lock_err_valid got=%b exp=0", ev4); end
    total++; if (eb4 !== 4'h0) begin bad++; $display("FAIL rst_lock_err_bits got=%h exp=0", eb4); end
    total++; if (ec4 !== 16'd0) begin bad++; $display("FAIL rst_lock_count got=%0d exp=0", ec4); end
    total++; if (bc4 !== 32'd0) begin bad++; $display("FAIL rst_lock_bit_count got=%0d exp=0", bc4); end
  endtask

  initial begin
    reset = 1'b1;
    dv1 = 1'b0; din1 = 1'b0; clr1 = 1'b0;
    dv4 = 1'b0; din4 = 4'h0; clr4 = 1'b0;
    test_reset();
    test_lock();
    test_single_err();
    test_clear();
    test_unlock();
    test_zeros();
    test_wide_gaps();
    test_saturate();
    test_reset_locked();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/galois_lfsr_checker.md
GALOIS_LFSR_CHECKER -- requirements
Module: galois_lfsr_checker

Interface
REQ-001 SHALL have parameter BITS_PER_CLOCK, default 1, meaning received sequence bits per valid word; legal values are 1, 2 and 4.
REQ-002 SHALL have parameter LOCK_BITS, default 32, meaning consecutive correct bits required to declare lock.
REQ-003 SHALL have parameter UNLOCK_ERRS, default 8, meaning bit errors within one 64-bit window that force loss of lock.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 data_valid  input  1  data_in holds a word this cycle.
REQ-008 data_in  input  BITS_PER_CLOCK  received sequence bits; bit [BITS_PER_CLOCK-1] oldest, bit 0 newest.
REQ-009 clear_count  input  1  single-cycle clear of error_count.
REQ-010 locked  output  1  checker is synchronised to the sequence.
REQ-011 err_valid  output  1  err_bits valid; data_valid delayed one cycle.
REQ-012 err_bits  output  BITS_PER_CLOCK  per-bit mismatch flags of the word accepted in the previous cycle.
REQ-013 error_count  output  16  saturating count of bit errors detected while locked.
REQ-014 bit_count  output  32  count of bits checked while locked.

Function
REQ-015 SHALL check against polynomial x^8+x^4+x^3+x^2+1: predicted bit p[n] = s[n-4]^s[n-5]^s[n-6]^s[n-8], using an 8-bit history of prior bits.
REQ-016 SHALL process the bits of a word serially, oldest first, within one cycle; a word is accepted only when data_valid=1, and no state changes when data_valid=0.
REQ-017 SHALL implement a two-state FSM, HUNT and LOCKED; on entering HUNT, history is cleared and fill count and run count are set to 0.
REQ-018 In HUNT, each bit shall shift into history; the first 8 bits after entering HUNT are fill only and are not compared.
REQ-019 In HUNT, after fill, a bit shall be counted good if it equals p[n] and history is non-zero; otherwise the run count shall reset to 0.
REQ-020 HUNT->LOCKED SHALL occur when the run count is >= LOCK_BITS at the end of an accepted word; locked rises in the following cycle.
REQ-021 In LOCKED, history SHALL shift in the predicted bit (free-running reference), so that one corrupted input bit yields exactly one error.
REQ-022 In LOCKED, mismatches SHALL set err_bits, add to error_count and add to the window error count; accepted bits SHALL add to bit_count.
REQ-023 The window SHALL span 64/BITS_PER_CLOCK accepted words; the window error count shall reset at each window boundary.
REQ-024 LOCKED->HUNT SHALL occur at the end of the word in which the window error count reaches UNLOCK_ERRS; locked falls in the following cycle.
REQ-025 In HUNT, err_bits SHALL be 0, and error_count and bit_count shall hold.
REQ-026 All outputs SHALL be registered, with latency of one cycle from the accepted word to err_valid and err_bits.
REQ-027 error_count SHALL saturate at 0xFFFF.
REQ-028 If clear_count and errors occur in the same cycle, the next error_count SHALL equal that word's error count.
REQ-029 bit_count SHALL wrap modulo 2^32 and is not affected by clear_count.
REQ-030 An all-zero input SHALL never achieve lock.

Reset
REQ-031 When reset=1 at a clock edge, the checker SHALL enter HUNT with history, fill, run and window counters at 0.
REQ-032 When reset=1 at a clock edge, locked, err_valid, err_bits, error_count and bit_count SHALL be 0.
REQ-033 Reset asserted mid-word or while LOCKED SHALL discard the accepted word.
REQ-034 Reset SHALL take priority over data_valid and clear_count.

Configuration
REQ-035 Macro LFSR_CHECKER_BITCOUNT_EN defined: bit_count SHALL be implemented per REQ-022/REQ-029.
REQ-036 Macro LFSR_CHECKER_BITCOUNT_EN undefined: bit_count SHALL be constant 0, no counter is instantiated, and all other behaviour is unchanged.

Verification
REQ-037 BITS_PER_CLOCK=1: drive a continuous sequence from a matching 8-bit Galois generator seeded 0x01 -> locked=1 in the cycle after the 40th valid word; error_count stays 0.
REQ-038 While locked, invert one bit -> a single err_bits=1 pulse, error_count=1, locked stays 1, no further errors follow.
REQ-039 Drive data_in=0 with data_valid=1 for 200 cycles -> locked stays 0 and error_count stays 0.
REQ-040 While locked, invert every 4th bit -> locked falls the cycle after the 8th error and error_count=8.
REQ-041 Assert clear_count in the same cycle as an erroring word with error_count=5 -> error_count=1; preload 0xFFFF plus one error -> error_count stays 0xFFFF.
REQ-042 BITS_PER_CLOCK=4 with random data_valid gaps and the generator enabled only on valid -> lock after 10 valid words; bit_count=4 per locked valid word (0 with macro undefined).
